ym3438_clk_phase: RTL

Two-phase clock-enable generator for the OPN2 core. It is the driving end of the c1/c2 interface: every shift-register, counter and latch primitive in the core samples on MCLK qualified by c1 or c2, and this block is the single source of those enables. It also keeps the 24-slot operator counter and emits the per-frame sync pulse that aligns slot-indexed pipelines.

---
 rtl/ym3438_clk_phase.sv | 68 ++++++
 1 files changed

// File: rtl/ym3438_clk_phase.sv
// ym3438_clk_phase: two-phase clock-enable generator for the OPN2 core.
// A divider d walks 0..2*PHASE_LEN-1 on each enabled MCLK. c1 fires at the
// end of phase 1 and c2 at the end of phase 2. A slot counter advances on
// every c2, and sync marks the c2 that closes the last slot of a frame.
// resync restarts both counters. IC clears them asynchronously.
module ym3438_clk_phase #(
    parameter int PHASE_LEN = 3,
    parameter int SLOTS     = 24
) (
    input  logic       MCLK,
    input  logic       IC,
    input  logic       en,
    input  logic       resync,
    output logic       c1,
    output logic       c2,
    output logic       phi1,
    output logic       phi2,
    output logic [4:0] slot,
    output logic       sync
);

    localparam int DW = $clog2(2 * PHASE_LEN);

    // Divider decode points: end of phase 1, end of phase 2, and phase boundary.
    localparam logic [DW-1:0] D_C1   = DW'(PHASE_LEN - 1);
    localparam logic [DW-1:0] D_C2   = DW'(2 * PHASE_LEN - 1);
    localparam logic [DW-1:0] D_HALF = DW'(PHASE_LEN);
    localparam logic [4:0]    SLOT_LAST = 5'(SLOTS - 1);

    logic [DW-1:0] d_q, d_d;
    logic [4:0]    slot_q, slot_d;

    // The enables are qualified by en and resync, so a stalled decode cycle
    // is deferred rather than dropped: d holds until en returns.
    assign c1   = en & ~resync & (d_q == D_C1);
    assign c2   = en & ~resync & (d_q == D_C2);
    assign phi1 = (d_q < D_HALF);
    assign phi2 = ~phi1;
    assign slot = slot_q;
    assign sync = c2 & (slot_q == SLOT_LAST);

    // Next-state: resync beats en; the slot moves only on the c2 edge.
    always_comb begin
        d_d    = d_q;
        slot_d = slot_q;
        if (resync) begin
            d_d    = '0;
            slot_d = '0;
        end else if (en) begin
            d_d = (d_q == D_C2) ? '0 : d_q + DW'(1);
            if (c2) begin
                slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 5'd1;
            end
        end
    end

    // State registers. IC clears them without waiting for an edge.
    always_ff @(posedge MCLK or negedge IC) begin
        if (!IC) begin
            d_q    <= '0;
            slot_q <= '0;
        end else begin
            d_q    <= d_d;
            slot_q <= slot_d;
        end
    end

endmodule
